sr_lock_arbiter: RTL

Round-robin lock arbiter that shares one SR-style ownership flag among N requesters. A requester is granted the lock by a set of the flag and gives it back by a reset of the flag. Exactly one owner is allowed at a time. It sits between the requesting control blocks and the shared resource they serialise on, and drives the flag's q/qb pair as busy/busy_n.

---
 rtl/sr_lock_arbiter_if.sv | 25 ++
 rtl/sr_lock_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sr_lock_arbiter_if.sv
// Request/grant bundle between the requesting control blocks and sr_lock_arbiter.
// The arbiter takes the slave side; the requesters take the master side.
interface sr_lock_arbiter_if #(
    parameter int unsigned N = 4
) ();
    localparam int unsigned OW = $clog2(N);

    logic [N-1:0]  req;
    logic [N-1:0]  rel;
    logic [N-1:0]  gnt;
    logic [OW-1:0] owner;
    logic          busy;
    logic          busy_n;
    logic          timeout;

    modport master (
        output req, rel,
        input  gnt, owner, busy, busy_n, timeout
    );

    modport slave (
        input  req, rel,
        output gnt, owner, busy, busy_n, timeout
    );
endinterface

// File: rtl/sr_lock_arbiter.sv
// Round-robin arbiter for a single SR-style ownership flag shared by N requesters.
// Optional hold watchdog enabled by defining SR_LOCK_TIMEOUT_EN.
module sr_lock_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sr_lock_arbiter_if.slave  bus
);
    localparam int unsigned OW = $clog2(N);

    if (N < 2 || TIMEOUT < 1 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_cfg_check
        $error("sr_lock_arbiter: illegal N/TIMEOUT/CNT_W combination");
    end

    typedef enum logic {IDLE, HELD} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] ptr_q, ptr_d;
    logic          busy_q, busy_d;
    logic          busy_n_q;
    logic [OW-1:0] winner_c;
    logic [OW-1:0] idx_c;
    logic          found_c;

`ifdef SR_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        winner_c = '0;
        idx_c    = '0;
        found_c  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx_c = OW'((32'(ptr_q) + i) % N);
            if (!found_c && bus.req[idx_c]) begin
                winner_c = idx_c;
                found_c  = 1'b1;
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
`ifdef SR_LOCK_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    gnt_d   = N'(1) << winner_c;
                    owner_d = winner_c;
                    busy_d  = 1'b1;
                    ptr_d   = OW'((32'(winner_c) + 1) % N);
                    state_d = HELD;
`ifdef SR_LOCK_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            HELD: begin
`ifdef SR_LOCK_TIMEOUT_EN
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
`endif
                // Release beats the owner's own req; non-owner rel bits are ignored.
                if (bus.rel[owner_q]) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
`ifdef SR_LOCK_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            busy_n_q <= 1'b1;
`ifdef SR_LOCK_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            busy_n_q <= ~busy_d;
`ifdef SR_LOCK_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.owner  = owner_q;
    assign bus.busy   = busy_q;
    assign bus.busy_n = busy_n_q;
`ifdef SR_LOCK_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif
endmodule
